btn_debounce: RTL and testbench



---
 rtl/btn_debounce_pkg.sv | 25 ++
 rtl/btn_debounce_ch.sv | 125 ++++++++++++
 rtl/btn_debounce.sv | 30 +++
 tb/tb_btn_debounce.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared types and constants for the button debouncer
package btn_debounce_pkg;

  // Per-channel FSM state; the encoding is exposed on debug_state, so keep it fixed
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } db_state_t;

  // Fewer than two stable samples would make the filter a plain pass-through
  localparam int DB_MIN_CYCLES = 2;

  // Width of the qualification counter; it only ever holds 0 .. cycles-1
  function automatic int db_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one debounce channel: 2-flop synchroniser, qualification FSM, counter
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_db,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic [1:0] debug_state
);
  import btn_debounce_pkg::*;

  localparam int CW = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < DB_MIN_CYCLES) begin : g_bad_cycles
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be at least 2");
  end

  logic          s1;
  logic          s2;
  db_state_t     state_q;
  db_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          db_q;
  logic          db_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  // Two-flop synchroniser; only s2 is ever looked at by the filter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= CNT_ZERO;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: a level is accepted after DEBOUNCE_CYCLES consecutive equal samples,
  // the first of which is counted on leaving the idle state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = CNT_ZERO;
        db_d    = 1'b0;
      end
    endcase
  end

  assign btn_db      = db_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign debug_state = state_q;

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - N independent debounce channels with concatenated debug state
module btn_debounce #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_db,
  output logic [N_BTN-1:0]   btn_rise,
  output logic [N_BTN-1:0]   btn_fall,
  output logic [2*N_BTN-1:0] debug_state
);
  import btn_debounce_pkg::*;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_db     (btn_db[i]),
      .btn_rise   (btn_rise[i]),
      .btn_fall   (btn_fall[i]),
      .debug_state(debug_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_db;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  logic [2*N-1:0] debug_state;

  int checks;
  int fails;

  btn_debounce #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_db     (btn_db),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .debug_state(debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    btn_raw = '0;
    reset   = 1'b1;
    tick();
    checks++;
    if (btn_db !== 4'b0000 || btn_rise !== 4'b0000 || btn_fall !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: db=%b rise=%b fall=%b, required all 0", btn_db, btn_rise, btn_fall);
    end
    checks++;
    if (debug_state !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: debug_state=%h, required 00", debug_state);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (btn_db !== 4'b0000 || debug_state !== 8'h00) begin
      fails++;
      $display("FAIL reset_idle: db=%b debug_state=%h, required 0000/00", btn_db, debug_state);
    end
  endtask

  task automatic test_rise();
    logic [1:0] exp_st;
    do_reset();
    btn_raw[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_st = (k < 2) ? 2'b00 : (k < 5) ? 2'b01 : 2'b10;
      checks++;
      if (btn_db[0] !== (k >= 5)) begin
        fails++;
        $display("FAIL rise_db edge%0d: db0=%b, required %b", k, btn_db[0], (k >= 5));
      end
      checks++;
      if (btn_rise[0] !== (k == 5) || btn_fall[0] !== 1'b0) begin
        fails++;
        $display("FAIL rise_pulse edge%0d: rise0=%b fall0=%b, required %b/0", k, btn_rise[0], btn_fall[0], (k == 5));
      end
      checks++;
      if (debug_state[1:0] !== exp_st) begin
        fails++;
        $display("FAIL rise_state edge%0d: state0=%b, required %b", k, debug_state[1:0], exp_st);
      end
    end
    btn_raw[0] = 1'b0;
  endtask

  task automatic test_short_pulse();
    do_reset();
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 2) btn_raw[1] = 1'b0;
      if (k == 4) begin
        checks++;
        if (debug_state[3:2] !== 2'b01) begin
          fails++;
          $display("FAIL short_wait: state1=%b, required 01", debug_state[3:2]);
        end
      end
      checks++;
      if (btn_db[1] !== 1'b0 || btn_rise[1] !== 1'b0) begin
        fails++;
        $display("FAIL short_suppress edge%0d: db1=%b rise1=%b, required 0/0", k, btn_db[1], btn_rise[1]);
      end
    end
    checks++;
    if (debug_state[3:2] !== 2'b00) begin
      fails++;
      $display("FAIL short_return: state1=%b, required 00", debug_state[3:2]);
    end
  endtask

  task automatic test_release_glitch();
    do_reset();
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (btn_db[2] !== 1'b1 || debug_state[5:4] !== 2'b10) begin
      fails++;
      $display("FAIL glitch_setup: db2=%b state2=%b, required 1/10", btn_db[2], debug_state[5:4]);
    end
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 1) btn_raw[2] = 1'b1;
      checks++;
      if (btn_db[2] !== 1'b1 || btn_fall[2] !== 1'b0 || btn_rise[2] !== 1'b0) begin
        fails++;
        $display("FAIL glitch_suppress edge%0d: db2=%b fall2=%b rise2=%b, required 1/0/0", k, btn_db[2], btn_fall[2], btn_rise[2]);
      end
    end
    checks++;
    if (debug_state[5:4] !== 2'b10) begin
      fails++;
      $display("FAIL glitch_return: state2=%b, required 10", debug_state[5:4]);
    end
    btn_raw[2] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_db[2] !== (k < 5)) begin
        fails++;
        $display("FAIL release_db edge%0d: db2=%b, required %b", k, btn_db[2], (k < 5));
      end
      checks++;
      if (btn_fall[2] !== (k == 5) || btn_rise[2] !== 1'b0) begin
        fails++;
        $display("FAIL release_pulse edge%0d: fall2=%b rise2=%b, required %b/0", k, btn_fall[2], btn_rise[2], (k == 5));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_raw = 4'b1111;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_db !== ((k >= 5) ? 4'b1111 : 4'b0000)) begin
        fails++;
        $display("FAIL simul_db edge%0d: db=%b, required %b", k, btn_db, ((k >= 5) ? 4'b1111 : 4'b0000));
      end
      checks++;
      if (btn_rise !== ((k == 5) ? 4'b1111 : 4'b0000)) begin
        fails++;
        $display("FAIL simul_rise edge%0d: rise=%b, required %b", k, btn_rise, ((k == 5) ? 4'b1111 : 4'b0000));
      end
    end
    checks++;
    if (debug_state !== 8'hAA) begin
      fails++;
      $display("FAIL simul_state: debug_state=%h, required aa", debug_state);
    end
    btn_raw = 4'b0000;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_fall !== ((k == 5) ? 4'b1111 : 4'b0000)) begin
        fails++;
        $display("FAIL simul_fall edge%0d: fall=%b, required %b", k, btn_fall, ((k == 5) ? 4'b1111 : 4'b0000));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    btn_raw[3] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (debug_state[7:6] !== 2'b01) begin
      fails++;
      $display("FAIL midwait_setup: state3=%b, required 01", debug_state[7:6]);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (debug_state !== 8'h00 || btn_db !== 4'b0000 || btn_rise !== 4'b0000) begin
      fails++;
      $display("FAIL midwait_async: debug_state=%h db=%b rise=%b, required 00/0000/0000", debug_state, btn_db, btn_rise);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_rise[3] !== (k == 5) || btn_db[3] !== (k >= 5)) begin
        fails++;
        $display("FAIL held_requal edge%0d: rise3=%b db3=%b, required %b/%b", k, btn_rise[3], btn_db[3], (k == 5), (k >= 5));
      end
    end
    btn_raw[3] = 1'b0;
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    reset   = 1'b1;
    btn_raw = '0;
    test_reset();
    test_rise();
    test_short_pulse();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
